aes128_cbc_sequencer: RTL and testbench

//  Controller for the AES-128 CBC encryptor datapath (key expansion, key scheduler, encrypt core).

---
 rtl/aes_cbc_pkg.sv | 29 ++
 rtl/cbc_latency_timer.sv | 34 +++
 rtl/aes128_cbc_sequencer.sv | 155 +++++++++++++++
 tb/tb_aes128_cbc_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_cbc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : aes_cbc_pkg
// Description : Shared constants and state encoding for the AES-128 CBC
//               sequencer and the encrypt-core wrapper.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
package aes_cbc_pkg;

  // Width of one AES block on every datapath bus
  localparam int AES_BLK_W = 128;

  // Fixed latencies of the expand/schedule path and of the encrypt core
  localparam int KEY_LATENCY_DEFAULT  = 12;
  localparam int CORE_LATENCY_DEFAULT = 11;

  // Counter width large enough for the longer of the two latencies
  localparam int CNT_W_DEFAULT = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    KEY_WAIT = 3'd1,
    READY    = 3'd2,
    RUN      = 3'd3,
    OUT      = 3'd4
  } cbc_state_t;

endpackage
`default_nettype wire

// File: rtl/cbc_latency_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : cbc_latency_timer
// Description : Loadable down-counter that saturates at zero. Used for both
//               the key-schedule wait and the encrypt-core wait.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module cbc_latency_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  // Load has priority; otherwise count down and stop at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (value != '0) begin
      value <= value - CNT_W'(1);
    end
  end

  // Zero flag is combinational so the FSM can act in the same cycle
  assign zero = (value == '0);

endmodule
`default_nettype wire

// File: rtl/aes128_cbc_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : aes128_cbc_sequencer
// Description : Controller for the AES-128 CBC encrypt datapath. Takes a
//               stream of plaintext blocks, feeds the core with the key,
//               the chaining vector and the block, waits the core latency
//               and returns the ciphertext. One block in flight at a time,
//               since each block chains on the previous ciphertext.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module aes128_cbc_sequencer
  import aes_cbc_pkg::*;
#(
  parameter int KEY_LATENCY  = KEY_LATENCY_DEFAULT,
  parameter int CORE_LATENCY = CORE_LATENCY_DEFAULT,
  parameter int CNT_W        = CNT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [AES_BLK_W-1:0] key_in,
  input  logic [AES_BLK_W-1:0] iv_in,
  input  logic                 pt_valid,
  output logic                 pt_ready,
  input  logic [AES_BLK_W-1:0] pt_data,
  input  logic                 pt_last,
  output logic                 ct_valid,
  input  logic                 ct_ready,
  output logic [AES_BLK_W-1:0] ct_data,
  output logic                 ct_last,
  output logic                 busy,
  output logic [15:0]          blk_count,
  output logic [AES_BLK_W-1:0] core_key,
  output logic [AES_BLK_W-1:0] core_vector,
  output logic [AES_BLK_W-1:0] core_plain_text,
  input  logic [AES_BLK_W-1:0] core_cipher_text
);

  cbc_state_t           state;
  logic [AES_BLK_W-1:0] chain_reg;
  logic                 last_reg;

  logic                 timer_load;
  logic [CNT_W-1:0]     timer_load_value;
  logic [CNT_W-1:0]     timer_value;
  logic                 timer_zero;

  // Timer is loaded on an accepted start (key wait) or plaintext handshake (core wait)
  always_comb begin
    timer_load       = 1'b0;
    timer_load_value = CNT_W'(CORE_LATENCY - 1);
    case (state)
      IDLE: begin
        if (start) begin
          timer_load       = 1'b1;
          timer_load_value = CNT_W'(KEY_LATENCY - 1);
        end
      end
      READY: begin
        if (pt_valid && pt_ready) begin
          timer_load = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  cbc_latency_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_load_value),
    .value      (timer_value),
    .zero       (timer_zero)
  );

  // Sequencing FSM; handshake flags are registered alongside the state so
  // pt_ready and ct_valid can never overlap
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      pt_ready        <= 1'b0;
      ct_valid        <= 1'b0;
      busy            <= 1'b0;
      ct_data         <= '0;
      ct_last         <= 1'b0;
      blk_count       <= '0;
      core_key        <= '0;
      core_vector     <= '0;
      core_plain_text <= '0;
      chain_reg       <= '0;
      last_reg        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            core_key  <= key_in;
            chain_reg <= iv_in;
            blk_count <= '0;
            busy      <= 1'b1;
            state     <= KEY_WAIT;
          end
        end
        KEY_WAIT: begin
          if (timer_zero) begin
            pt_ready <= 1'b1;
            state    <= READY;
          end
        end
        READY: begin
          if (pt_valid && pt_ready) begin
            core_plain_text <= pt_data;
            core_vector     <= chain_reg;
            last_reg        <= pt_last;
            pt_ready        <= 1'b0;
            state           <= RUN;
          end
        end
        RUN: begin
          if (timer_zero) begin
            ct_data   <= core_cipher_text;
            chain_reg <= core_cipher_text;
            ct_last   <= last_reg;
            ct_valid  <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (ct_valid && ct_ready) begin
            blk_count <= blk_count + 16'd1;
            ct_valid  <= 1'b0;
            if (ct_last) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              pt_ready <= 1'b1;
              state    <= READY;
            end
          end
        end
        default: begin
          pt_ready <= 1'b0;
          ct_valid <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes128_cbc_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_aes128_cbc_sequencer
// Description : Scoreboard bench for the AES-128 CBC sequencer with a
//               behavioural encrypt core built on a reference AES model.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_aes128_cbc_sequencer;

  localparam int KEY_LAT  = 12;
  localparam int CORE_LAT = 11;

  localparam logic [127:0] KEY    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1     = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C1     = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] P2     = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C2     = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] ALTKEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] ALTIV  = 128'hffeeddccbbaa99887766554433221100;

  logic         clk = 1'b0;
  logic         reset, start, pt_valid, pt_last, ct_ready;
  logic [127:0] key_in, iv_in, pt_data;
  logic         pt_ready, ct_valid, ct_last, busy;
  logic [127:0] ct_data, core_key, core_vector, core_plain_text, core_cipher_text;
  logic [15:0]  blk_count;

  always #5 clk = ~clk;

  aes128_cbc_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .key_in           (key_in),
    .iv_in            (iv_in),
    .pt_valid         (pt_valid),
    .pt_ready         (pt_ready),
    .pt_data          (pt_data),
    .pt_last          (pt_last),
    .ct_valid         (ct_valid),
    .ct_ready         (ct_ready),
    .ct_data          (ct_data),
    .ct_last          (ct_last),
    .busy             (busy),
    .blk_count        (blk_count),
    .core_key         (core_key),
    .core_vector      (core_vector),
    .core_plain_text  (core_plain_text),
    .core_cipher_text (core_cipher_text)
  );

  // ---------------- reference AES-128 ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x, r;
    x = a; r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      x = gmul(x, x);
      r = gmul(r, x);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] key, input logic [127:0] blk);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox(tmp[31:24]) ^ rc, sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])};
        rc  = xtime(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox(s[i]);
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          s[row + 4*c] = t[row + 4*((c + row) % 4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
          s[4*c+3] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- behavioural core ----------------
  // Output is the true CBC ciphertext only once key and data inputs have been
  // stable long enough; before that it presents the inverted value.
  logic [127:0] m_key, m_vec, m_pt, ref_ct;
  int           key_cnt = 0;
  int           dat_cnt = 0;

  initial begin
    m_key = '0; m_vec = '0; m_pt = '0;
  end

  always @(negedge clk) begin
    m_key   <= core_key;
    m_vec   <= core_vector;
    m_pt    <= core_plain_text;
    key_cnt <= (core_key != m_key) ? 1 : ((key_cnt < 1000) ? key_cnt + 1 : key_cnt);
    dat_cnt <= (core_vector != m_vec || core_plain_text != m_pt) ? 1 :
               ((dat_cnt < 1000) ? dat_cnt + 1 : dat_cnt);
  end

  assign ref_ct = aes_encrypt(core_key, core_vector ^ core_plain_text);
  assign core_cipher_text = (key_cnt >= KEY_LAT && dat_cnt >= CORE_LAT) ? ref_ct : ~ref_ct;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic         last;
    logic [127:0] ct;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;
  int   cyc    = 0;
  int   hs_cyc = 0;
  int   st_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard on every output handshake
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!reset) begin
      if (ct_valid && pt_ready) begin
        total++;
        $display("FAIL ready_valid_overlap: ct_valid=%b pt_ready=%b required not both", ct_valid, pt_ready);
      end
      if (ct_valid && ct_ready) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_ct: got %h expected no output", ct_data);
        end else begin
          e = sb.pop_front();
          check("ct_data", ct_data, e.ct);
          check("ct_last", {127'd0, ct_last}, {127'd0, e.last});
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_start(input logic [127:0] k, input logic [127:0] v);
    key_in = k; iv_in = v; start = 1'b1;
    st_cyc = cyc;
    @(negedge clk);
    start = 1'b0; key_in = ~k; iv_in = ~v;
  endtask

  task automatic wait_pt_ready(input string name);
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (pt_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    check(name, ok ? 128'(cyc - st_cyc) : 128'hdead, 128'(KEY_LAT + 1));
  endtask

  task automatic send_block(input logic [127:0] p, input logic l, input logic [127:0] c);
    bit ok = 0;
    pt_data = p; pt_last = l; pt_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (pt_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      total++;
      $display("FAIL pt_handshake_timeout: got no pt_ready expected handshake");
    end else begin
      hs_cyc = cyc;
      sb.push_back('{last: l, ct: c});
    end
    @(negedge clk);
    pt_valid = 1'b0;
  endtask

  task automatic wait_ct_valid(input string name);
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (ct_valid) begin ok = 1; break; end
      @(negedge clk);
    end
    check(name, ok ? 128'(cyc - hs_cyc) : 128'hdead, 128'(CORE_LAT + 1));
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      total++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed tests ----------------
  initial begin
    bit hold_ok, rdy_ok, vld_ok;
    reset = 1'b1; start = 1'b0; pt_valid = 1'b0; pt_last = 1'b0; ct_ready = 1'b1;
    key_in = '0; iv_in = '0; pt_data = '0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {ct_data, 16'(0), blk_count, 3'(0), ct_valid, pt_ready, busy, ct_last},
          '0);
    check("rst_core_bus", core_key | core_vector | core_plain_text, '0);
    reset = 1'b0;
    @(negedge clk);

    // CBC vector with latency checks
    do_start(KEY, IV);
    wait_pt_ready("start_to_ready");
    send_block(P1, 1'b0, C1);
    wait_ct_valid("latency_blk1");
    wait_done();
    check("blk_count_1", 128'(blk_count), 128'd1);
    send_block(P2, 1'b1, C2);
    wait_ct_valid("latency_blk2");
    wait_done();
    check("busy_after_last", 128'(busy), 128'd0);
    check("blk_count_2", 128'(blk_count), 128'd2);

    // Backpressure, then a start pulse during RUN with another key
    do_start(KEY, IV);
    wait_pt_ready("start_to_ready_m2");
    ct_ready = 1'b0;
    send_block(P1, 1'b0, C1);
    wait_ct_valid("latency_bp");
    pt_data = P2; pt_last = 1'b1; pt_valid = 1'b1;
    hold_ok = 1; rdy_ok = 1; vld_ok = 1;
    for (int i = 0; i < 20; i++) begin
      if (ct_data !== C1) hold_ok = 0;
      if (pt_ready !== 1'b0) rdy_ok = 0;
      if (ct_valid !== 1'b1) vld_ok = 0;
      @(negedge clk);
    end
    check("bp_ct_stable", 128'(hold_ok), 128'd1);
    check("bp_pt_ready_low", 128'(rdy_ok), 128'd1);
    check("bp_ct_valid_held", 128'(vld_ok), 128'd1);
    check("bp_pending", 128'(sb.size()), 128'd1);
    ct_ready = 1'b1;
    send_block(P2, 1'b1, C2);
    repeat (2) @(negedge clk);
    do_start(ALTKEY, ALTIV);
    check("start_in_run_busy", 128'(busy), 128'd1);
    wait_ct_valid("latency_after_start_pulse");
    wait_done();
    check("busy_after_m2", 128'(busy), 128'd0);

    // Reset in the middle of RUN
    do_start(KEY, IV);
    wait_pt_ready("start_to_ready_m3");
    send_block(P1, 1'b0, C1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    sb.delete();
    check("midrun_rst_outputs", {ct_data, 16'(0), blk_count, 3'(0), ct_valid, pt_ready, busy, ct_last},
          '0);
    check("midrun_rst_core_bus", core_key | core_vector | core_plain_text, '0);
    reset = 1'b0;
    @(negedge clk);
    do_start(KEY, IV);
    wait_pt_ready("start_to_ready_after_rst");
    send_block(P1, 1'b0, C1);
    wait_ct_valid("latency_after_rst");
    wait_done();
    send_block(P2, 1'b1, C2);
    wait_done();
    check("blk_count_after_rst_msg", 128'(blk_count), 128'd2);

    // Back-to-back message with the same IV restarts the chain and the count
    @(negedge clk);
    do_start(KEY, IV);
    wait_pt_ready("start_to_ready_m5");
    check("blk_count_restart", 128'(blk_count), 128'd0);
    send_block(P1, 1'b0, C1);
    wait_done();
    check("blk_count_m5_1", 128'(blk_count), 128'd1);
    send_block(P2, 1'b1, C2);
    wait_done();
    check("blk_count_m5_2", 128'(blk_count), 128'd2);
    check("busy_end", 128'(busy), 128'd0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
